// File: rtl/ahb_apb_pkg.sv
// Shared AHB-side encodings, slave address map and error-FSM state type
// for the AHB slave interface of the AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Three 64 MB peripheral windows, laid out back to back
    localparam logic [31:0] SLV0_BASE   = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE   = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE   = 32'h8800_0000;
    localparam logic [31:0] REGION_SIZE = 32'h0400_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    function automatic logic trans_active(input logic hready, input logic [1:0] trans);
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: return hready;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder: maps haddr onto a one-hot peripheral
// select, all-zero when the address hits no peripheral window.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] haddr,
    output logic [2:0]        tempselx
);

    // Widened so the window compares stay correct for any ADDR_W up to 64
    logic [63:0] addr_w;
    assign addr_w = 64'(haddr);

    function automatic logic in_window(input logic [63:0] a, input logic [31:0] base);
        return (a >= 64'(base)) && (a < (64'(base) + 64'(REGION_SIZE)));
    endfunction

    always_comb begin
        tempselx = 3'b000;
        if (in_window(addr_w, SLV0_BASE))
            tempselx = 3'b001;
        else if (in_window(addr_w, SLV1_BASE))
            tempselx = 3'b010;
        else if (in_window(addr_w, SLV2_BASE))
            tempselx = 3'b100;
    end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end: address/data pipeline, peripheral decode and
// optional two-cycle ERROR response (enabled by AHB_SLV_ERR_RESP_EN).
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hwrite,
    input  logic              hreadyin,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic              valid,
    output logic [ADDR_W-1:0] haddr1,
    output logic [ADDR_W-1:0] haddr2,
    output logic [DATA_W-1:0] hwdata1,
    output logic [DATA_W-1:0] hwdata2,
    output logic              hwritereg,
    output logic [2:0]        tempselx,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp,
    output logic              hready_err
`ifdef AHB_SLV_ERR_RESP_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    logic              active;
    logic              fsm_idle;
    logic [ADDR_W-1:0] haddr1_q, haddr2_q;
    logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
    logic              hwritereg_q;

    assign active = trans_active(hreadyin, htrans);

    ahb_addr_decode #(.ADDR_W(ADDR_W)) u_addr_decode (
        .haddr    (haddr),
        .tempselx (tempselx)
    );

    // Address/data pipe: stalls as a whole while the bus is not ready
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1_q    <= '0;
            haddr2_q    <= '0;
            hwdata1_q   <= '0;
            hwdata2_q   <= '0;
            hwritereg_q <= 1'b0;
        end else if (hreadyin) begin
            haddr1_q    <= haddr;
            haddr2_q    <= haddr1_q;
            hwdata1_q   <= hwdata;
            hwdata2_q   <= hwdata1_q;
            hwritereg_q <= hwrite;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    err_state_e state_q;
    logic [1:0] hresp_q;
    logic       hready_err_q;
    logic [7:0] err_cnt_q;

    // Two-cycle ERROR: first cycle stalls the master, second releases it
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            hresp_q      <= HRESP_OKAY;
            hready_err_q <= 1'b1;
            err_cnt_q    <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (active && (tempselx == 3'b000)) begin
                        state_q      <= ST_ERR1;
                        hresp_q      <= HRESP_ERROR;
                        hready_err_q <= 1'b0;
                        if (err_cnt_q != 8'hFF)
                            err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
                ST_ERR1: begin
                    state_q      <= ST_ERR2;
                    hresp_q      <= HRESP_ERROR;
                    hready_err_q <= 1'b1;
                end
                ST_ERR2: begin
                    state_q      <= ST_IDLE;
                    hresp_q      <= HRESP_OKAY;
                    hready_err_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    hresp_q      <= HRESP_OKAY;
                    hready_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign fsm_idle   = (state_q == ST_IDLE);
    assign hresp      = hresp_q;
    assign hready_err = hready_err_q;
    assign err_cnt    = err_cnt_q;
`else
    assign fsm_idle   = 1'b1;
    assign hresp      = HRESP_OKAY;
    assign hready_err = 1'b1;
`endif

    assign valid     = active && (tempselx != 3'b000) && fsm_idle;
    assign haddr1    = haddr1_q;
    assign haddr2    = haddr2_q;
    assign hwdata1   = hwdata1_q;
    assign hwdata2   = hwdata2_q;
    assign hwritereg = hwritereg_q;
    assign hrdata    = prdata;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Testbench for ahb_slave_interface; error-response checks follow
// AHB_SLV_ERR_RESP_EN the same way the design does.
module tb_ahb_slave_interface;

`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] haddr1, haddr2;
    logic [31:0] hwdata1, hwdata2;
    logic        hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        hready_err;
`ifdef AHB_SLV_ERR_RESP_EN
    logic [7:0]  err_cnt;
`endif

    int nchk = 0;
    int npass = 0;

    // Reference model state
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w;
    int          m_err_left;   // cycles of error response still to show (2 = first cycle)
    int          m_cnt;

    always #5 hclk = ~hclk;

    ahb_slave_interface #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hwrite     (hwrite),
        .hreadyin   (hreadyin),
        .htrans     (htrans),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .prdata     (prdata),
        .valid      (valid),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwdata1    (hwdata1),
        .hwdata2    (hwdata2),
        .hwritereg  (hwritereg),
        .tempselx   (tempselx),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .hready_err (hready_err)
`ifdef AHB_SLV_ERR_RESP_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(32'h8000_0000);
        if (off >= 0 && off < 3 * longint'(32'h0400_0000))
            return 3'b001 << (off / longint'(32'h0400_0000));
        return 3'b000;
    endfunction

    function automatic bit exp_active();
        return hreadyin && (htrans >= 2'd2);
    endfunction

    function automatic bit exp_valid();
        return exp_active() && (exp_sel(haddr) != 3'b000) && (m_err_left == 0);
    endfunction

    task automatic model_clear();
        m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_w = 1'b0;
        m_err_left = 0; m_cnt = 0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge
    task automatic cycle();
        int nleft;
        int ncnt;
        nleft = (m_err_left > 0) ? m_err_left - 1 : 0;
        ncnt  = m_cnt;
        if (ERR_EN && m_err_left == 0 && exp_active() && exp_sel(haddr) == 3'b000) begin
            nleft = 2;
            if (ncnt < 255) ncnt++;
        end
        if (hreadyin) begin
            m_a2 = m_a1; m_a1 = haddr;
            m_d2 = m_d1; m_d1 = hwdata;
            m_w  = hwrite;
        end
        m_err_left = nleft;
        m_cnt      = ncnt;
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_reset();
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        model_clear();
    endtask

    task automatic bus_idle();
        hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00;
        haddr = 32'h0; hwdata = 32'h0; prdata = 32'h0;
    endtask

    task automatic test_reset();
        bus_idle();
        haddr  = 32'h8000_0000;
        htrans = 2'b10;
        hresetn = 1'b0;
        #1;
        nchk++; if (haddr1 !== 32'h0) $display("FAIL rst_haddr1 got=%h exp=0", haddr1); else npass++;
        nchk++; if (hwdata2 !== 32'h0) $display("FAIL rst_hwdata2 got=%h exp=0", hwdata2); else npass++;
        nchk++; if (hwritereg !== 1'b0) $display("FAIL rst_hwritereg got=%b exp=0", hwritereg); else npass++;
        nchk++; if (hresp !== 2'b00) $display("FAIL rst_hresp got=%b exp=00", hresp); else npass++;
        nchk++; if (hready_err !== 1'b1) $display("FAIL rst_hready_err got=%b exp=1", hready_err); else npass++;
`ifdef AHB_SLV_ERR_RESP_EN
        nchk++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); else npass++;
`endif
        @(posedge hclk);
        #1;
        nchk++; if (haddr1 !== 32'h0) $display("FAIL rst_hold_haddr1 got=%h exp=0", haddr1); else npass++;
        hresetn = 1'b1;
        model_clear();
        bus_idle();
    endtask

    task automatic test_write_pipe();
        bus_idle();
        hwrite = 1'b1; htrans = 2'b10; haddr = 32'h8000_0020; hwdata = 32'h0;
        #1;
        nchk++; if (valid !== 1'b1) $display("FAIL wr_valid got=%b exp=1", valid); else npass++;
        nchk++; if (tempselx !== 3'b001) $display("FAIL wr_sel got=%b exp=001", tempselx); else npass++;
        cycle();
        nchk++; if (haddr1 !== 32'h8000_0020) $display("FAIL wr_haddr1 got=%h exp=80000020", haddr1); else npass++;
        nchk++; if (hwritereg !== 1'b1) $display("FAIL wr_hwritereg got=%b exp=1", hwritereg); else npass++;
        htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'hDEAD_BEEF;
        cycle();
        nchk++; if (haddr2 !== 32'h8000_0020) $display("FAIL wr_haddr2 got=%h exp=80000020", haddr2); else npass++;
        nchk++; if (hwdata1 !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata1 got=%h exp=deadbeef", hwdata1); else npass++;
        hwdata = 32'h0;
        cycle();
        nchk++; if (hwdata2 !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata2 got=%h exp=deadbeef", hwdata2); else npass++;
    endtask

    task automatic test_idle_busy();
        bus_idle();
        haddr = 32'h8800_0004;
        for (int t = 0; t < 2; t++) begin
            htrans = 2'(t);
            #1;
            nchk++; if (valid !== 1'b0) $display("FAIL ib_valid htrans=%0d got=%b exp=0", t, valid); else npass++;
            nchk++; if (tempselx !== 3'b100) $display("FAIL ib_sel got=%b exp=100", tempselx); else npass++;
            cycle();
            nchk++; if (hresp !== 2'b00) $display("FAIL ib_hresp got=%b exp=00", hresp); else npass++;
        end
        bus_idle();
    endtask

    task automatic test_error();
        apply_reset();
        bus_idle();
        htrans = 2'b10; haddr = 32'h9000_0000;
        #1;
        nchk++; if (valid !== 1'b0) $display("FAIL err_valid got=%b exp=0", valid); else npass++;
        cycle();
`ifdef AHB_SLV_ERR_RESP_EN
        nchk++; if (hresp !== 2'b01 || hready_err !== 1'b0) $display("FAIL err_c1 got=%b/%b exp=01/0", hresp, hready_err); else npass++;
        haddr = 32'h8400_0000;
        #1;
        nchk++; if (valid !== 1'b0) $display("FAIL err_ignore_valid got=%b exp=0", valid); else npass++;
        cycle();
        nchk++; if (hresp !== 2'b01 || hready_err !== 1'b1) $display("FAIL err_c2 got=%b/%b exp=01/1", hresp, hready_err); else npass++;
        htrans = 2'b00;
        cycle();
        nchk++; if (hresp !== 2'b00 || hready_err !== 1'b1) $display("FAIL err_c3 got=%b/%b exp=00/1", hresp, hready_err); else npass++;
        nchk++; if (err_cnt !== 8'd1) $display("FAIL err_cnt got=%0d exp=1", err_cnt); else npass++;
`else
        nchk++; if (hresp !== 2'b00 || hready_err !== 1'b1) $display("FAIL noerr_resp got=%b/%b exp=00/1", hresp, hready_err); else npass++;
`endif
        bus_idle();
        cycle();
    endtask

    task automatic test_hold();
        logic [31:0] a1, a2, d1, d2;
        logic        w;
        bus_idle();
        for (int i = 0; i < 2; i++) begin
            haddr = $urandom; hwdata = $urandom; hwrite = 1'b1;
            cycle();
        end
        a1 = haddr1; a2 = haddr2; d1 = hwdata1; d2 = hwdata2; w = hwritereg;
        hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            haddr = $urandom; hwdata = $urandom; hwrite = 1'b0; htrans = 2'b10;
            cycle();
            nchk++; if (haddr1 !== a1 || haddr2 !== a2) $display("FAIL hold_addr got=%h/%h exp=%h/%h", haddr1, haddr2, a1, a2); else npass++;
            nchk++; if (hwdata1 !== d1 || hwdata2 !== d2) $display("FAIL hold_data got=%h/%h exp=%h/%h", hwdata1, hwdata2, d1, d2); else npass++;
            nchk++; if (hwritereg !== w) $display("FAIL hold_hwritereg got=%b exp=%b", hwritereg, w); else npass++;
        end
        nchk++; if (haddr1 !== m_a1) $display("FAIL hold_model got=%h exp=%h", haddr1, m_a1); else npass++;
        bus_idle();
    endtask

    task automatic test_reset_mid_error();
        apply_reset();
        bus_idle();
        htrans = 2'b10; haddr = 32'h9000_0000; hwrite = 1'b1;
        cycle();
        hresetn = 1'b0;
        #1;
        nchk++; if (hresp !== 2'b00 || hready_err !== 1'b1) $display("FAIL rme_resp got=%b/%b exp=00/1", hresp, hready_err); else npass++;
        nchk++; if (haddr1 !== 32'h0) $display("FAIL rme_haddr1 got=%h exp=0", haddr1); else npass++;
        #2;
        bus_idle();
        hresetn = 1'b1;
        model_clear();
        cycle();
        nchk++; if (hresp !== 2'b00 || hready_err !== 1'b1) $display("FAIL rme_after got=%b/%b exp=00/1", hresp, hready_err); else npass++;
        htrans = 2'b10; haddr = 32'h8000_0000;
        #1;
        nchk++; if (valid !== 1'b1) $display("FAIL rme_idle_valid got=%b exp=1", valid); else npass++;
        bus_idle();
        cycle();
    endtask

    task automatic test_saturation();
        int bad;
        apply_reset();
        bus_idle();
        bad = 0;
        htrans = 2'b10;
        for (int i = 0; i < 256 * 3; i++) begin
            haddr = 32'hC000_0000 | ($urandom & 32'h00FF_FFFC);
            cycle();
            if (!ERR_EN && hresp != 2'b00) bad++;
        end
        nchk++; if (bad !== 0) $display("FAIL sat_hresp_bad got=%0d exp=0", bad); else npass++;
`ifdef AHB_SLV_ERR_RESP_EN
        nchk++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); else npass++;
        for (int i = 0; i < 6; i++) cycle();
        nchk++; if (err_cnt !== 8'(m_cnt)) $display("FAIL sat_err_cnt_hold got=%0d exp=%0d", err_cnt, m_cnt); else npass++;
`endif
        bus_idle();
        repeat (3) cycle();
    endtask

    task automatic test_random();
        logic [31:0] picks [6];
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            picks[0] = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
            picks[1] = 32'h8BFF_FFFF;
            picks[2] = 32'h8C00_0000;
            picks[3] = 32'h7FFF_FFFF;
            picks[4] = $urandom;
            picks[5] = 32'h8400_0000 + ($urandom & 32'hFF);
            haddr    = picks[$urandom_range(0, 5)];
            htrans   = 2'($urandom);
            hreadyin = ($urandom_range(0, 3) != 0);
            hwrite   = 1'($urandom);
            hwdata   = $urandom;
            prdata   = $urandom;
            #1;
            nchk++; if (tempselx !== exp_sel(haddr)) $display("FAIL rnd_sel a=%h got=%b exp=%b", haddr, tempselx, exp_sel(haddr)); else npass++;
            nchk++; if (valid !== exp_valid()) $display("FAIL rnd_valid a=%h got=%b exp=%b", haddr, valid, exp_valid()); else npass++;
            nchk++; if (hrdata !== prdata) $display("FAIL rnd_hrdata got=%h exp=%h", hrdata, prdata); else npass++;
            cycle();
            nchk++; if (haddr1 !== m_a1 || haddr2 !== m_a2) $display("FAIL rnd_addr got=%h/%h exp=%h/%h", haddr1, haddr2, m_a1, m_a2); else npass++;
            nchk++; if (hwdata1 !== m_d1 || hwdata2 !== m_d2) $display("FAIL rnd_data got=%h/%h exp=%h/%h", hwdata1, hwdata2, m_d1, m_d2); else npass++;
            nchk++; if (hwritereg !== m_w) $display("FAIL rnd_hwritereg got=%b exp=%b", hwritereg, m_w); else npass++;
            nchk++; if (hresp !== ((m_err_left > 0) ? 2'b01 : 2'b00)) $display("FAIL rnd_hresp got=%b left=%0d", hresp, m_err_left); else npass++;
            nchk++; if (hready_err !== (m_err_left != 2)) $display("FAIL rnd_hready_err got=%b left=%0d", hready_err, m_err_left); else npass++;
`ifdef AHB_SLV_ERR_RESP_EN
            nchk++; if (err_cnt !== 8'(m_cnt)) $display("FAIL rnd_err_cnt got=%0d exp=%0d", err_cnt, m_cnt); else npass++;
`endif
        end
        bus_idle();
    endtask

    initial begin
        hresetn = 1'b0;
        bus_idle();
        model_clear();
        #2;
        test_reset();
        test_write_pipe();
        test_idle_busy();
        test_error();
        test_hold();
        test_reset_mid_error();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
